// File: rtl/execute_stage.sv
// RV32I execute stage: ID/EX register, ALU, branch/jump resolution with a
// combinational fetch redirect, and the EX/MEM register.
// Optional feature macro: EX_ILLEGAL_ALU_TRAP_EN adds o_illegal_m and kills
// write enables of entries carrying an unlisted ALU code.
//
// Pipeline control: i_stall_e holds both registers and suppresses the redirect.
// i_flush_e, or a redirect raised by the instruction in EX, loads a bubble into
// ID/EX. Per-register priority is reset > stall > flush > load.
module execute_stage #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid_d,
    input  logic [4:0]      i_alu_ctrl_d,
    input  logic [XLEN-1:0] i_rs1_data_d,
    input  logic [XLEN-1:0] i_rs2_data_d,
    input  logic [XLEN-1:0] i_imm_d,
    input  logic [XLEN-1:0] i_pc_d,
    input  logic [4:0]      i_rd_d,
    input  logic            i_reg_write_d,
    input  logic            i_mem_write_d,
    input  logic            i_src_a_pc_d,
    input  logic            i_src_b_imm_d,
    input  logic            i_jump_d,
    input  logic            i_jalr_d,
    input  logic            i_stall_e,
    input  logic            i_flush_e,
    output logic            o_pc_src_e,
    output logic [XLEN-1:0] o_branch_target_e,
    output logic            o_valid_m,
    output logic [XLEN-1:0] o_alu_result_m,
    output logic [XLEN-1:0] o_write_data_m,
    output logic [4:0]      o_rd_m,
    output logic            o_reg_write_m,
    output logic            o_mem_write_m,
    output logic [XLEN-1:0] o_pc_plus4_m
`ifdef EX_ILLEGAL_ALU_TRAP_EN
    ,
    output logic            o_illegal_m
`endif
);

    // All state resets to zero; the reset vector is kept only for interface compatibility.
    logic unused_reset_vector;
    assign unused_reset_vector = ^RESET_VECTOR;

    logic            idex_valid;
    logic [4:0]      idex_alu_ctrl;
    logic [XLEN-1:0] idex_rs1;
    logic [XLEN-1:0] idex_rs2;
    logic [XLEN-1:0] idex_imm;
    logic [XLEN-1:0] idex_pc;
    logic [4:0]      idex_rd;
    logic            idex_reg_write;
    logic            idex_mem_write;
    logic            idex_src_a_pc;
    logic            idex_src_b_imm;
    logic            idex_jump;
    logic            idex_jalr;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            code_legal;
    logic            is_branch;
    logic            branch_cond;
    logic            write_ok;
    logic [XLEN-1:0] jalr_sum;

    // ID/EX register: hold on stall, bubble on flush or self-squash, else load
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idex_valid     <= 1'b0;
            idex_alu_ctrl  <= '0;
            idex_rs1       <= '0;
            idex_rs2       <= '0;
            idex_imm       <= '0;
            idex_pc        <= '0;
            idex_rd        <= '0;
            idex_reg_write <= 1'b0;
            idex_mem_write <= 1'b0;
            idex_src_a_pc  <= 1'b0;
            idex_src_b_imm <= 1'b0;
            idex_jump      <= 1'b0;
            idex_jalr      <= 1'b0;
        end else if (!i_stall_e) begin
            if (i_flush_e || o_pc_src_e) begin
                idex_valid     <= 1'b0;
                idex_reg_write <= 1'b0;
                idex_mem_write <= 1'b0;
                idex_jump      <= 1'b0;
            end else begin
                idex_valid     <= i_valid_d;
                idex_alu_ctrl  <= i_alu_ctrl_d;
                idex_rs1       <= i_rs1_data_d;
                idex_rs2       <= i_rs2_data_d;
                idex_imm       <= i_imm_d;
                idex_pc        <= i_pc_d;
                idex_rd        <= i_rd_d;
                idex_reg_write <= i_valid_d & i_reg_write_d;
                idex_mem_write <= i_valid_d & i_mem_write_d;
                idex_src_a_pc  <= i_src_a_pc_d;
                idex_src_b_imm <= i_src_b_imm_d;
                idex_jump      <= i_valid_d & i_jump_d;
                idex_jalr      <= i_jalr_d;
            end
        end
    end

    assign src_a = idex_src_a_pc  ? idex_pc  : idex_rs1;
    assign src_b = idex_src_b_imm ? idex_imm : idex_rs2;

    // ALU and branch condition; unlisted or unknown codes fall to the default arm
    always_comb begin
        alu_result  = '0;
        code_legal  = 1'b1;
        is_branch   = 1'b0;
        branch_cond = 1'b0;
        case (idex_alu_ctrl)
            5'd0:  alu_result = src_a & src_b;
            5'd1:  alu_result = src_a | src_b;
            5'd2:  alu_result = src_a ^ src_b;
            5'd3:  alu_result = src_a + src_b;
            5'd4:  alu_result = src_a - src_b;
            5'd5:  alu_result = src_a << src_b[4:0];
            5'd6:  alu_result = src_a >> src_b[4:0];
            5'd7:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            5'd8:  alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            5'd9:  alu_result = $signed(src_a) >>> src_b[4:0];
            5'd10: begin is_branch = 1'b1; branch_cond = (idex_rs1 == idex_rs2); end
            5'd11: begin is_branch = 1'b1; branch_cond = (idex_rs1 != idex_rs2); end
            5'd12: begin is_branch = 1'b1; branch_cond = ($signed(idex_rs1) < $signed(idex_rs2)); end
            5'd13: begin is_branch = 1'b1; branch_cond = (idex_rs1 < idex_rs2); end
            5'd14: begin is_branch = 1'b1; branch_cond = ($signed(idex_rs1) >= $signed(idex_rs2)); end
            5'd15: begin is_branch = 1'b1; branch_cond = (idex_rs1 >= idex_rs2); end
            5'd16: alu_result = src_b;
            default: code_legal = 1'b0;
        endcase
    end

    // Redirect is suppressed during stall and reset; unlisted codes never redirect
    assign jalr_sum          = idex_rs1 + idex_imm;
    assign o_branch_target_e = idex_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (idex_pc + idex_imm);
    assign o_pc_src_e        = idex_valid & ~i_stall_e & ~i_rst & code_legal
                             & (idex_jump | (is_branch & branch_cond));

`ifdef EX_ILLEGAL_ALU_TRAP_EN
    assign write_ok = code_legal;
`else
    assign write_ok = 1'b1;
`endif

    // EX/MEM register: advances whenever not stalled; a bubble carries zero enables
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid_m      <= 1'b0;
            o_alu_result_m <= '0;
            o_write_data_m <= '0;
            o_rd_m         <= '0;
            o_reg_write_m  <= 1'b0;
            o_mem_write_m  <= 1'b0;
            o_pc_plus4_m   <= '0;
        end else if (!i_stall_e) begin
            o_valid_m      <= idex_valid;
            o_alu_result_m <= alu_result;
            o_write_data_m <= idex_rs2;
            o_rd_m         <= idex_rd;
            o_reg_write_m  <= idex_valid & idex_reg_write & write_ok;
            o_mem_write_m  <= idex_valid & idex_mem_write & write_ok;
            o_pc_plus4_m   <= idex_pc + XLEN'(4);
        end
    end

`ifdef EX_ILLEGAL_ALU_TRAP_EN
    // Illegal flag travels with its EX/MEM entry
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_illegal_m <= 1'b0;
        end else if (!i_stall_e) begin
            o_illegal_m <= idex_valid & ~code_legal;
        end
    end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed scenarios plus a randomized stream
// checked cycle by cycle against a transaction-level reference model.
module tb_execute_stage;

    localparam int W = 105;  // {valid, rw, mw, illegal, rd[5], result, wdata, pc4}

    typedef struct packed {
        logic        valid;
        logic [4:0]  code;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic        a_pc;
        logic        b_imm;
        logic        jump;
        logic        jalr;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_d, reg_write_d, mem_write_d, src_a_pc_d, src_b_imm_d, jump_d, jalr_d;
    logic [4:0]  alu_ctrl_d, rd_d;
    logic [31:0] rs1_d, rs2_d, imm_d, pc_d;
    logic        stall_e, flush_e;
    logic        pc_src_e, valid_m, reg_write_m, mem_write_m;
    logic [31:0] target_e, result_m, wdata_m, pc4_m;
    logic [4:0]  rd_m;
    logic        illegal_m;

    int vectors = 0;
    int miscompares = 0;

    bundle_t        ex_m;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   cur_exp;

    execute_stage dut (
        .i_clk(clk), .i_rst(rst), .i_valid_d(valid_d), .i_alu_ctrl_d(alu_ctrl_d),
        .i_rs1_data_d(rs1_d), .i_rs2_data_d(rs2_d), .i_imm_d(imm_d), .i_pc_d(pc_d),
        .i_rd_d(rd_d), .i_reg_write_d(reg_write_d), .i_mem_write_d(mem_write_d),
        .i_src_a_pc_d(src_a_pc_d), .i_src_b_imm_d(src_b_imm_d), .i_jump_d(jump_d),
        .i_jalr_d(jalr_d), .i_stall_e(stall_e), .i_flush_e(flush_e),
        .o_pc_src_e(pc_src_e), .o_branch_target_e(target_e), .o_valid_m(valid_m),
        .o_alu_result_m(result_m), .o_write_data_m(wdata_m), .o_rd_m(rd_m),
        .o_reg_write_m(reg_write_m), .o_mem_write_m(mem_write_m), .o_pc_plus4_m(pc4_m)
`ifdef EX_ILLEGAL_ALU_TRAP_EN
        , .o_illegal_m(illegal_m)
`endif
    );

`ifndef EX_ILLEGAL_ALU_TRAP_EN
    assign illegal_m = 1'b0;
`endif

    // clock / reset
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic is_legal(input logic [4:0] c);
        return c <= 5'd16;
    endfunction

    function automatic logic [31:0] ref_result(input bundle_t b);
        logic [31:0] a, bb;
        logic signed [31:0] sa;
        a  = b.a_pc ? b.pc : b.rs1;
        bb = b.b_imm ? b.imm : b.rs2;
        sa = a;
        case (b.code)
            5'd0:  return a & bb;
            5'd1:  return a | bb;
            5'd2:  return a ^ bb;
            5'd3:  return a + bb;
            5'd4:  return a - bb;
            5'd5:  return a << bb[4:0];
            5'd6:  return a >> bb[4:0];
            5'd7:  return ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
            5'd8:  return (a < bb) ? 32'd1 : 32'd0;
            5'd9:  return sa >>> bb[4:0];
            5'd16: return bb;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input bundle_t b);
        if (!b.valid || !is_legal(b.code)) return 1'b0;
        if (b.jump) return 1'b1;
        case (b.code)
            5'd10: return b.rs1 == b.rs2;
            5'd11: return b.rs1 != b.rs2;
            5'd12: return $signed(b.rs1) < $signed(b.rs2);
            5'd13: return b.rs1 < b.rs2;
            5'd14: return $signed(b.rs1) >= $signed(b.rs2);
            5'd15: return b.rs1 >= b.rs2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input bundle_t b);
        return b.jalr ? ((b.rs1 + b.imm) & 32'hFFFF_FFFE) : (b.pc + b.imm);
    endfunction

    function automatic logic [W-1:0] mem_pack(input bundle_t b);
        logic ok, ill;
`ifdef EX_ILLEGAL_ALU_TRAP_EN
        ok  = is_legal(b.code);
        ill = b.valid & ~is_legal(b.code);
`else
        ok  = 1'b1;
        ill = 1'b0;
`endif
        return {b.valid, b.valid & b.rw & ok, b.valid & b.mw & ok, ill, b.rd,
                ref_result(b), b.rs2, b.pc + 32'd4};
    endfunction

    function automatic bundle_t nop_b();
        bundle_t b;
        b = '0;
        return b;
    endfunction

    function automatic bundle_t rand_b();
        bundle_t b;
        b.valid = ($urandom_range(0, 7) != 0);
        b.code  = 5'($urandom_range(0, 19));
        b.rs1   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        b.rs2   = ($urandom_range(0, 3) == 0) ? b.rs1 : $urandom;
        b.imm   = $urandom;
        b.pc    = $urandom & 32'hFFFF_FFFC;
        b.rd    = 5'($urandom_range(0, 31));
        b.rw    = 1'($urandom_range(0, 1));
        b.mw    = 1'($urandom_range(0, 1));
        b.a_pc  = 1'($urandom_range(0, 1));
        b.b_imm = 1'($urandom_range(0, 1));
        b.jump  = ($urandom_range(0, 7) == 0);
        b.jalr  = b.jump & 1'($urandom_range(0, 1));
        return b;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bundle_t b, input logic stall, input logic flush);
        valid_d = b.valid; alu_ctrl_d = b.code; rs1_d = b.rs1; rs2_d = b.rs2;
        imm_d = b.imm; pc_d = b.pc; rd_d = b.rd; reg_write_d = b.rw; mem_write_d = b.mw;
        src_a_pc_d = b.a_pc; src_b_imm_d = b.b_imm; jump_d = b.jump; jalr_d = b.jalr;
        stall_e = stall; flush_e = flush;
    endtask

    // One cycle: drive, check at the falling edge against the model, advance the model at the rising edge
    task automatic step(input bundle_t b, input logic stall, input logic flush);
        logic         exp_redirect;
        logic [W-1:0] dut_pack;
        logic [3:0]   ctl_mask_exp, ctl_mask_dut;
        drive(b, stall, flush);
        @(negedge clk);
        if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
        exp_redirect = ref_taken(ex_m) & ~stall;
        vectors++;
        if (pc_src_e !== exp_redirect) begin
            $display("FAIL pc_src: got %b expected %b", pc_src_e, exp_redirect);
            miscompares++;
        end
        if (exp_redirect) begin
            vectors++;
            if (target_e !== ref_target(ex_m)) begin
                $display("FAIL target: got %h expected %h", target_e, ref_target(ex_m));
                miscompares++;
            end
        end
        dut_pack = {valid_m, reg_write_m, mem_write_m, illegal_m, rd_m, result_m, wdata_m, pc4_m};
        vectors++;
        if (cur_exp[W-1]) begin
            if (dut_pack !== cur_exp) begin
                $display("FAIL exmem: got %h expected %h", dut_pack, cur_exp);
                miscompares++;
            end
        end else begin
            ctl_mask_dut = dut_pack[W-1:W-4];
            ctl_mask_exp = cur_exp[W-1:W-4];
            if (ctl_mask_dut !== ctl_mask_exp) begin
                $display("FAIL exmem_bubble: got %b expected %b", ctl_mask_dut, ctl_mask_exp);
                miscompares++;
            end
        end
        @(posedge clk);
        if (!stall) begin
            exp_q.push_back(mem_pack(ex_m));
            if (flush || exp_redirect) ex_m.valid = 1'b0;
            else ex_m = b;
        end
        #1;
    endtask

    task automatic model_reset();
        ex_m    = nop_b();
        cur_exp = '0;
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(nop_b(), 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        vectors++;
        if ({valid_m, reg_write_m, mem_write_m, illegal_m} !== 4'b0) begin
            $display("FAIL reset_ctl: got %b expected 0000", {valid_m, reg_write_m, mem_write_m, illegal_m});
            miscompares++;
        end
        vectors++;
        if ({result_m, wdata_m, pc4_m, rd_m} !== '0) begin
            $display("FAIL reset_data: got %h %h %h %h expected 0", result_m, wdata_m, pc4_m, rd_m);
            miscompares++;
        end
        vectors++;
        if (pc_src_e !== 1'b0 || target_e !== 32'd0) begin
            $display("FAIL reset_redirect: got %b %h expected 0 0", pc_src_e, target_e);
            miscompares++;
        end
    endtask

    task automatic test_add();
        bundle_t b;
        b = nop_b();
        b.valid = 1; b.code = 5'd3; b.rs1 = 5; b.rs2 = 7; b.rd = 9; b.rw = 1; b.pc = 32'h40;
        step(b, 0, 0);
        step(nop_b(), 0, 0);
        vectors++;
        if (valid_m !== 1'b1 || result_m !== 32'd12 || rd_m !== 5'd9 || reg_write_m !== 1'b1) begin
            $display("FAIL add: got v=%b r=%h rd=%0d rw=%b expected v=1 r=0000000c rd=9 rw=1",
                     valid_m, result_m, rd_m, reg_write_m);
            miscompares++;
        end
    endtask

    task automatic test_shift();
        bundle_t b;
        b = nop_b();
        b.valid = 1; b.code = 5'd9; b.rs1 = 32'h8000_0000; b.imm = 4; b.b_imm = 1; b.rw = 1;
        step(b, 0, 0);
        b.code = 5'd6;
        step(b, 0, 0);
        vectors++;
        if (result_m !== 32'hF800_0000) begin
            $display("FAIL sra: got %h expected f8000000", result_m);
            miscompares++;
        end
        step(nop_b(), 0, 0);
        vectors++;
        if (result_m !== 32'h0800_0000) begin
            $display("FAIL srl: got %h expected 08000000", result_m);
            miscompares++;
        end
    endtask

    task automatic test_branch();
        bundle_t b, w;
        b = nop_b();
        b.valid = 1; b.code = 5'd10; b.rs1 = 3; b.rs2 = 3; b.pc = 32'h100; b.imm = 32'h20;
        step(b, 0, 0);
        vectors++;
        if (pc_src_e !== 1'b1 || target_e !== 32'h120) begin
            $display("FAIL beq: got %b %h expected 1 00000120", pc_src_e, target_e);
            miscompares++;
        end
        w = nop_b();
        w.valid = 1; w.code = 5'd3; w.rw = 1; w.rd = 4;
        step(w, 0, 0);
        step(nop_b(), 0, 0);
        vectors++;
        if (valid_m !== 1'b0 || reg_write_m !== 1'b0) begin
            $display("FAIL squash: got v=%b rw=%b expected v=0 rw=0", valid_m, reg_write_m);
            miscompares++;
        end
        b.code = 5'd11;
        step(b, 0, 0);
        vectors++;
        if (pc_src_e !== 1'b0) begin
            $display("FAIL bne: got %b expected 0", pc_src_e);
            miscompares++;
        end
        step(nop_b(), 0, 0);
    endtask

    task automatic test_jalr();
        bundle_t b;
        b = nop_b();
        b.valid = 1; b.code = 5'd3; b.rs1 = 32'h203; b.imm = 4; b.b_imm = 1;
        b.jump = 1; b.jalr = 1; b.pc = 32'h300; b.rd = 1; b.rw = 1;
        step(b, 0, 0);
        vectors++;
        if (pc_src_e !== 1'b1 || target_e !== 32'h206) begin
            $display("FAIL jalr_target: got %b %h expected 1 00000206", pc_src_e, target_e);
            miscompares++;
        end
        step(nop_b(), 0, 0);
        vectors++;
        if (valid_m !== 1'b1 || pc4_m !== 32'h304) begin
            $display("FAIL jalr_link: got v=%b %h expected v=1 00000304", valid_m, pc4_m);
            miscompares++;
        end
    endtask

    task automatic test_stall();
        bundle_t b1, b2, b3;
        b1 = nop_b(); b1.valid = 1; b1.code = 5'd3; b1.rs1 = 100; b1.rs2 = 23; b1.rw = 1; b1.rd = 2;
        b2 = nop_b(); b2.valid = 1; b2.code = 5'd13; b2.rs1 = 1; b2.rs2 = 2; b2.pc = 32'h80; b2.imm = 8;
        b3 = nop_b(); b3.valid = 1; b3.code = 5'd1; b3.rs1 = 32'hF0; b3.rs2 = 32'h0F; b3.rw = 1; b3.rd = 3;
        step(b1, 0, 0);
        step(b2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(b3, 1, 0);
            vectors++;
            if (pc_src_e !== 1'b0 || result_m !== 32'd123) begin
                $display("FAIL stall_hold: got %b %h expected 0 0000007b", pc_src_e, result_m);
                miscompares++;
            end
        end
        step(b3, 0, 0);
        step(b3, 0, 0);
        step(nop_b(), 0, 0);
        step(nop_b(), 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(rand_b(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
        end
        step(nop_b(), 0, 0);
        step(nop_b(), 0, 0);
    endtask

    task automatic test_reset_midflight();
        bundle_t a, b;
        a = nop_b(); a.valid = 1; a.code = 5'd3; a.rs1 = 1; a.rs2 = 2; a.rw = 1; a.mw = 1; a.rd = 7; a.pc = 32'h10;
        b = nop_b(); b.valid = 1; b.code = 5'd10; b.pc = 32'h20; b.imm = 32'h40; b.rw = 0;
        step(a, 0, 0);
        step(b, 0, 0);
        drive(a, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (pc_src_e !== 1'b0) begin
            $display("FAIL reset_no_redirect: got %b expected 0", pc_src_e);
            miscompares++;
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({valid_m, reg_write_m, mem_write_m, illegal_m, pc_src_e} !== 5'b0 ||
            {result_m, wdata_m, pc4_m, rd_m, target_e} !== '0) begin
            $display("FAIL reset_midflight: got v=%b rw=%b mw=%b r=%h pc4=%h tgt=%h expected all 0",
                     valid_m, reg_write_m, mem_write_m, result_m, pc4_m, target_e);
            miscompares++;
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_illegal();
        bundle_t b;
        b = nop_b();
        b.valid = 1; b.code = 5'd20; b.rs1 = 9; b.rs2 = 9; b.rw = 1; b.mw = 1; b.rd = 5;
        step(b, 0, 0);
        step(nop_b(), 0, 0);
`ifdef EX_ILLEGAL_ALU_TRAP_EN
        vectors++;
        if (illegal_m !== 1'b1 || reg_write_m !== 1'b0 || mem_write_m !== 1'b0 || result_m !== 32'd0) begin
            $display("FAIL illegal_trap: got ill=%b rw=%b mw=%b r=%h expected 1 0 0 0",
                     illegal_m, reg_write_m, mem_write_m, result_m);
            miscompares++;
        end
`else
        vectors++;
        if (reg_write_m !== 1'b1 || mem_write_m !== 1'b1 || result_m !== 32'd0 || valid_m !== 1'b1) begin
            $display("FAIL illegal_pass: got v=%b rw=%b mw=%b r=%h expected 1 1 1 0",
                     valid_m, reg_write_m, mem_write_m, result_m);
            miscompares++;
        end
`endif
        step(nop_b(), 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(nop_b(), 1'b0, 1'b0);
        model_reset();
        test_reset();
        test_add();
        test_shift();
        test_branch();
        test_jalr();
        test_stall();
        test_random();
        test_reset_midflight();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
